// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants, opcodes and fetch state encoding
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} fetch_state_t;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: next-PC select (hold / pc+4 / aligned redirect) and misalignment detect
module fetch_next_pc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);
  // redirect wins over sequential advance, which wins over hold
  always_comb begin
    next_pc = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : advance ? pc + XLEN'(4) : pc;
    misaligned = redirect_valid & |redirect_pc[1:0];
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, imem req/gnt/rvalid fetch FSM and decode holding register
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic            misaligned_err
);
  import riscv_pkg::*;
  fetch_state_t state, state_d;
  logic [XLEN-1:0] pc, next_pc;
  logic discard, discard_d, capture, misaligned;
  fetch_next_pc #(.XLEN(XLEN)) u_next_pc (
    .pc(pc),
    .advance(state == VALID && id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .next_pc(next_pc),
    .misaligned(misaligned)
  );
  // next state; a redirect with a fetch in flight marks its response for dropping
  always_comb begin
    state_d = state;
    discard_d = discard;
    capture = 1'b0;
    case (state)
      IDLE: state_d = REQ;
      REQ: if (imem_gnt) begin
        state_d = WAIT;
        discard_d = redirect_valid;
      end
      WAIT: if (imem_rvalid) begin
        capture = !(discard || redirect_valid);
        state_d = capture ? VALID : REQ;
        discard_d = 1'b0;
      end else if (redirect_valid) discard_d = 1'b1;
      default: if (id_ready || redirect_valid) state_d = REQ;
    endcase
  end
  // state, PC and holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      discard <= 1'b0;
      misaligned_err <= 1'b0;
      id_inst <= '0;
      id_pc <= '0;
    end else begin
      state <= state_d;
      pc <= next_pc;
      discard <= discard_d;
      misaligned_err <= misaligned_err | misaligned;
      if (capture) begin
        id_inst <= imem_rdata;
        id_pc <= pc;
      end
    end
  end
  // outputs derive from registers only
  always_comb begin
    imem_req = state == REQ;
    imem_addr = pc;
    id_valid = state == VALID;
    id_pc_plus4 = id_pc + XLEN'(4);
    id_opcode = id_inst[6:0];
    id_funct3 = id_inst[14:12];
    id_funct7 = id_inst[31:25];
    id_rd = id_inst[11:7];
    id_rs1 = id_inst[19:15];
    id_rs2 = id_inst[24:20];
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the control unit in the single-issue RISC-V core.
- Owns the PC and fetches 32-bit instructions from instruction memory over a req/gnt/rvalid handshake.
- Holds each fetched instruction with its PC and decoded fields (opcode, funct3, funct7 feed the control unit) until decode accepts it via valid/ready.
- Applies redirects from the branch/jump resolution path, discarding stale in-flight fetches.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset; one clock; reset is asynchronous and active-high
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address, word-aligned
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
redirect_valid  in  1  take redirect_pc as next PC
redirect_pc  in  XLEN  branch/jump target
id_valid  out  1  instruction held for decode
id_ready  in  1  decode accepts held instruction
id_inst  out  32  held instruction
id_pc  out  XLEN  PC of held instruction
id_pc_plus4  out  XLEN  id_pc + 4 (link value for jal/jalr)
id_opcode  out  7  id_inst[6:0]
id_funct3  out  3  id_inst[14:12]
id_funct7  out  7  id_inst[31:25]
id_rd  out  5  id_inst[11:7]
id_rs1  out  5  id_inst[19:15]
id_rs2  out  5  id_inst[24:20]
misaligned_err  out  1  sticky: a redirect target had bits[1:0] != 0

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, discard=0, misaligned_err=0.
  - id_inst=0, id_valid=0, imem_req=0.
  - All id_* outputs are 0 except id_pc_plus4=4.
- States and transitions:
  - IDLE: 1 cycle after reset release, then go to REQ.
  - REQ: imem_req=1, imem_addr=pc. On gnt, go to WAIT.
  - WAIT: imem_req=0. On rvalid:
    - discard=0: capture id_inst<=rdata and id_pc<=pc; go to VALID.
    - discard=1: drop the data, clear discard, go to REQ.
  - VALID: id_valid=1; id_inst, id_pc and decoded fields stay stable. On id_ready: pc<=pc+4, go to REQ.
- Timing:
  - Minimum 3 cycles per instruction: REQ with gnt, WAIT with rvalid, VALID with ready.
  - gnt may be held off indefinitely; imem_addr stays stable while imem_req=1.
- Redirects (pc<=redirect_pc & ~3 in every case):
  - In REQ without gnt: next REQ cycle uses the new address.
  - In REQ with gnt in the same cycle: go to WAIT with discard=1.
  - In WAIT without rvalid: discard<=1.
  - In WAIT with rvalid in the same cycle: drop the data, go to REQ.
  - In VALID: held instruction dropped (id_valid=0 next cycle), go to REQ. If id_ready is also high, the handshake counts but the next PC is the redirect target, not pc+4.
  - In IDLE: overrides RESET_PC.
- Misaligned target: redirect_pc[1:0]!=0 sets misaligned_err (stays set until reset); fetch continues from the aligned address.
- PC arithmetic is modulo 2^XLEN; 0xFFFF_FFFC + 4 wraps to 0.
- rvalid outside WAIT is ignored. gnt outside REQ is ignored.
- Reset mid-transaction returns to IDLE; any later response from the aborted fetch is ignored.

Decomposition:
- Shared package riscv_pkg:
  - XLEN
  - opcode constants: OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_JAL=1101111, OP_JALR=1100111, OP_LUI=0110111, OP_AUIPC=0010111
  - NOP=32'h0000_0013
  - fetch_state_t enum {IDLE, REQ, WAIT, VALID}
- Sub-module fetch_next_pc: combinational next-PC mux (hold / pc+4 / aligned redirect) plus misalignment detect. The FSM and registers stay in instr_fetch_unit.

Test Plan:
1. Reset release, gnt=1 immediately, rvalid next cycle with 32'h0050_0093 -> imem_addr=0x0; then id_valid=1, id_inst=0x00500093, id_opcode=0010011, id_rd=1, id_rs1=0, id_pc=0, id_pc_plus4=4.
2. Hold id_ready=0 for 5 cycles in VALID -> id_valid and id_inst stable, imem_req=0; on ready=1 the next request has imem_addr=0x4.
3. redirect_pc=0x100 during WAIT, then rvalid with 0xDEAD_BEEF -> id_valid stays 0, next request imem_addr=0x100, that response delivered with id_pc=0x100.
4. In VALID at id_pc=0x8, id_ready=1 and redirect_pc=0x40 in the same cycle -> next imem_addr=0x40 (not 0xC).
5. redirect_pc=0x102 -> misaligned_err=1 and stays set, next imem_addr=0x100; only rst clears it.
6. rst asserted mid-WAIT -> id_valid, imem_req and misaligned_err drop without a clock edge; later rvalid ignored; after release first request is at RESET_PC.
